decimal_timer_60min: RTL and testbench

Counts elapsed time in BCD (MM:SS.t) from the 10 Hz square wave produced by the upstream 100 MHz → 10 Hz divider. Provides start/pause/clear control and drives the divider's enable, which keeps the tick phase aligned to each start. Output digits feed the seven-segment display driver. Stops at a programmable minute limit, 60:00.0 by default.

---
 rtl/decimal_timer_60min_pkg.sv | 30 +++
 rtl/decimal_timer_60min_if.sv | 28 ++
 rtl/decimal_timer_60min_bcd_digit_counter.sv | 47 ++++
 rtl/decimal_timer_60min.sv | 130 +++++++++++++
 tb/tb_decimal_timer_60min.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/decimal_timer_60min_pkg.sv
// Shared definitions for the 60-minute decimal timer.
//   state_e          : FSM state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3)
//   DIGIT_MAX_DEC    : top value of a decimal digit (9)
//   DIGIT_MAX_SEXT   : top value of the seconds-tens digit (5)
//   MIN_TENS_MAX     : top value of the minutes-tens digit (6)
//   SLOW_PERIOD_CYC  : clk_sys cycles per 10 Hz tick, for benches
//   to_bcd2()        : whole number 0..99 to {tens, ones} BCD
package decimal_timer_60min_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int DIGIT_MAX_DEC   = 9;
  localparam int DIGIT_MAX_SEXT  = 5;
  localparam int MIN_TENS_MAX    = 6;
  localparam int SLOW_PERIOD_CYC = 10_000_000;

  function automatic logic [7:0] to_bcd2(input int unsigned v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'((v / 10) % 10);
    ones = 4'(v % 10);
    return {tens, ones};
  endfunction

endpackage

// File: rtl/decimal_timer_60min_if.sv
// Control and display bundle of the decimal timer.
//   Slow_Clk_In, Start, Stop, Clear : controller -> timer
//   Div_En, Running, Done, digits   : timer -> controller / display
// master = the side driving controls, slave = the timer itself.
interface decimal_timer_60min_if;
  logic       Slow_Clk_In;
  logic       Start;
  logic       Stop;
  logic       Clear;
  logic       Div_En;
  logic       Running;
  logic       Done;
  logic [2:0] Min_Tens;
  logic [3:0] Min_Ones;
  logic [2:0] Sec_Tens;
  logic [3:0] Sec_Ones;
  logic [3:0] Tenths;

  modport master (
    output Slow_Clk_In, Start, Stop, Clear,
    input  Div_En, Running, Done, Min_Tens, Min_Ones, Sec_Tens, Sec_Ones, Tenths
  );

  modport slave (
    input  Slow_Clk_In, Start, Stop, Clear,
    output Div_En, Running, Done, Min_Tens, Min_Ones, Sec_Tens, Sec_Ones, Tenths
  );
endinterface

// File: rtl/decimal_timer_60min_bcd_digit_counter.sv
// One BCD digit of the timer: counts 0..MAX and wraps to 0 with a carry.
//   clk, rst_n : clock, synchronous active-low reset
//   inc        : advance by one this cycle
//   clr        : force to zero (wins over inc)
//   digit      : registered digit value
//   digit_nxt  : value the digit takes at the next edge
//   carry      : inc while at MAX, i.e. the next digit must advance too
module bcd_digit_counter #(
  parameter int MAX = 9,
  parameter int W   = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] digit,
  output logic [W-1:0] digit_nxt,
  output logic         carry
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] digit_q;
  logic [W-1:0] digit_d;

  always_comb begin
    carry   = inc && (digit_q == MAX_V);
    digit_d = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (inc) begin
      digit_d = (digit_q == MAX_V) ? '0 : digit_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit     = digit_q;
  assign digit_nxt = digit_d;

endmodule

// File: rtl/decimal_timer_60min.sv
// Stopwatch counting MM:SS.t in BCD from the 10 Hz divider output.
//   Clk_In      : 100 MHz clock
//   Rst_n       : synchronous active-low reset
//   bus (slave) : Slow_Clk_In/Start/Stop/Clear in; Div_En, Running, Done
//                 and the five BCD digits out
//   LIMIT_MIN   : halt when the count reaches LIMIT_MIN:00.0 (1..60)
//
// state | meaning
// ------+------------------------------------------
// IDLE  | count zero, waiting for Start
// RUN   | divider enabled, counting ticks
// PAUSE | count held, divider disabled
// DONE  | count held at LIMIT_MIN:00.0 until Clear
module decimal_timer_60min
  import decimal_timer_60min_pkg::*;
#(
  parameter int LIMIT_MIN = 60
) (
  input logic                  Clk_In,
  input logic                  Rst_n,
  decimal_timer_60min_if.slave bus
);

  localparam logic [2:0] LIM_TENS = 3'(LIMIT_MIN / 10);
  localparam logic [3:0] LIM_ONES = 4'(LIMIT_MIN % 10);

  state_e state_q, state_d;
  logic   prev_q, prev_d;
  logic   tick_q, tick_d;
  logic   running_q, running_d;
  logic   done_q, done_d;

  logic       inc_en;
  logic       terminal;
  logic       c_t, c_so, c_st, c_mo, c_mt;
  logic [3:0] t_cur, t_nxt;
  logic [3:0] so_cur, so_nxt;
  logic [2:0] st_cur, st_nxt;
  logic [3:0] mo_cur, mo_nxt;
  logic [2:0] mt_cur, mt_nxt;

  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC), .W(4)) u_tenths (
    .clk(Clk_In), .rst_n(Rst_n), .inc(inc_en), .clr(bus.Clear),
    .digit(t_cur), .digit_nxt(t_nxt), .carry(c_t)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC), .W(4)) u_sec_ones (
    .clk(Clk_In), .rst_n(Rst_n), .inc(c_t), .clr(bus.Clear),
    .digit(so_cur), .digit_nxt(so_nxt), .carry(c_so)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_SEXT), .W(3)) u_sec_tens (
    .clk(Clk_In), .rst_n(Rst_n), .inc(c_so), .clr(bus.Clear),
    .digit(st_cur), .digit_nxt(st_nxt), .carry(c_st)
  );

  bcd_digit_counter #(.MAX(DIGIT_MAX_DEC), .W(4)) u_min_ones (
    .clk(Clk_In), .rst_n(Rst_n), .inc(c_st), .clr(bus.Clear),
    .digit(mo_cur), .digit_nxt(mo_nxt), .carry(c_mo)
  );

  bcd_digit_counter #(.MAX(MIN_TENS_MAX), .W(3)) u_min_tens (
    .clk(Clk_In), .rst_n(Rst_n), .inc(c_mo), .clr(bus.Clear),
    .digit(mt_cur), .digit_nxt(mt_nxt), .carry(c_mt)
  );

  always_comb begin
    // Falling edge is registered before use, so an increment lands two
    // edges after the input drops.
    prev_d = bus.Slow_Clk_In;
    tick_d = prev_q & ~bus.Slow_Clk_In;

    // A tick seen outside RUN (e.g. the divider output dropping as Div_En
    // falls) is discarded here.
    inc_en = (state_q == ST_RUN) && tick_q && !bus.Clear && !bus.Stop;

    terminal = (mt_nxt == LIM_TENS) && (mo_nxt == LIM_ONES) &&
               (st_nxt == 3'd0) && (so_nxt == 4'd0) && (t_nxt == 4'd0);

    state_d = state_q;
    if (bus.Clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (!bus.Stop && bus.Start) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (bus.Stop) begin
            state_d = ST_PAUSE;
          end else if (inc_en && (terminal || c_mt)) begin
            // A full-range rollover also halts rather than wrapping to zero.
            state_d = ST_DONE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end

    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk_In) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      prev_q    <= 1'b0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= prev_d;
      tick_q    <= tick_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.Div_En   = running_q;
  assign bus.Running  = running_q;
  assign bus.Done     = done_q;
  assign bus.Min_Tens = mt_cur;
  assign bus.Min_Ones = mo_cur;
  assign bus.Sec_Tens = st_cur;
  assign bus.Sec_Ones = so_cur;
  assign bus.Tenths   = t_cur;

endmodule

// File: tb/tb_decimal_timer_60min.sv
// Bench for decimal_timer_60min: two instances (limit 60 and limit 1) share
// one stimulus stream. A tenths-count model is compared every cycle and a
// set of literal expectations pins key points of the run.
module tb_decimal_timer_60min;

  logic clk = 1'b0;
  logic rst_n;
  logic slow, start, stop, clear;
  logic chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  decimal_timer_60min_if bus_a ();
  decimal_timer_60min_if bus_b ();

  assign bus_a.Slow_Clk_In = slow;
  assign bus_a.Start       = start;
  assign bus_a.Stop        = stop;
  assign bus_a.Clear       = clear;
  assign bus_b.Slow_Clk_In = slow;
  assign bus_b.Start       = start;
  assign bus_b.Stop        = stop;
  assign bus_b.Clear       = clear;

  decimal_timer_60min #(.LIMIT_MIN(60)) dut_a (
    .Clk_In(clk), .Rst_n(rst_n), .bus(bus_a)
  );

  decimal_timer_60min #(.LIMIT_MIN(1)) dut_b (
    .Clk_In(clk), .Rst_n(rst_n), .bus(bus_b)
  );

  // {mt, mo, st, so, t, div_en, running, done}
  wire [20:0] act_a = {bus_a.Min_Tens, bus_a.Min_Ones, bus_a.Sec_Tens, bus_a.Sec_Ones,
                       bus_a.Tenths, bus_a.Div_En, bus_a.Running, bus_a.Done};
  wire [20:0] act_b = {bus_b.Min_Tens, bus_b.Min_Ones, bus_b.Sec_Tens, bus_b.Sec_Ones,
                       bus_b.Tenths, bus_b.Div_En, bus_b.Running, bus_b.Done};

  function automatic logic [20:0] lit(int mt, int mo, int st, int so, int t,
                                      int run, int done);
    return {3'(mt), 4'(mo), 3'(st), 4'(so), 4'(t), 1'(run), 1'(run), 1'(done)};
  endfunction

  // Model: count of elapsed tenths plus a mode (0 idle, 1 run, 2 pause, 3 done).
  int m_cnt [2];
  int m_mode[2];
  int m_lim [2] = '{60, 1};
  logic h0, h1;   // Slow_Clk_In as seen at the previous edge and the one before
  logic m_tick;

  function automatic logic [20:0] model_vec(int c, int md);
    int m;
    m = c / 600;
    return lit(m / 10, m % 10, (c % 600) / 100, (c % 100) / 10, c % 10,
               (md == 1) ? 1 : 0, (md == 3) ? 1 : 0);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_cnt[i]  = 0;
        m_mode[i] = 0;
      end
      h0 = 1'b0;
      h1 = 1'b0;
    end else begin
      // A fall between two samples takes effect one edge after it is seen.
      m_tick = h1 && !h0;
      for (int i = 0; i < 2; i++) begin
        if (clear) begin
          m_mode[i] = 0;
          m_cnt[i]  = 0;
        end else if (m_mode[i] == 1) begin
          if (stop) begin
            m_mode[i] = 2;
          end else if (m_tick) begin
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] >= m_lim[i] * 600) m_mode[i] = 3;
          end
        end else if (m_mode[i] == 0 || m_mode[i] == 2) begin
          if (start && !stop) m_mode[i] = 1;
        end
      end
      h1 = h0;
      h0 = slow;
    end
  end

  task automatic check(input string name, input logic [20:0] got, input logic [20:0] want);
    n_checks++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s at %0t: got %h want %h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_lim60", act_a, model_vec(m_cnt[0], m_mode[0]));
      check("model_lim1",  act_b, model_vec(m_cnt[1], m_mode[1]));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns #1 after the edge that first samples Slow_Clk_In low.
  task automatic ticks(input int n);
    repeat (n) begin
      slow = 1'b1;
      step(1);
      slow = 1'b0;
      step(1);
    end
  endtask

  task automatic lit_a(input string name, input logic [20:0] want);
    @(negedge clk);
    check(name, act_a, want);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    clear = 1'b0;
    slow  = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    lit_a("reset", lit(0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    start = 1'b0;
    step(1);

    start = 1'b1;
    step(1);
    start = 1'b0;
    lit_a("start_run", lit(0, 0, 0, 0, 0, 1, 0));

    ticks(10);
    lit_a("latency_pre", lit(0, 0, 0, 0, 9, 1, 0));
    lit_a("basic_1s", lit(0, 0, 0, 1, 0, 1, 0));

    ticks(589);
    step(1);
    lit_a("preload_59_9", lit(0, 0, 5, 9, 9, 1, 0));
    ticks(1);
    step(1);
    @(negedge clk);
    check("carry_chain", act_a, lit(0, 1, 0, 0, 0, 1, 0));
    check("small_limit", act_b, lit(0, 1, 0, 0, 0, 0, 1));
    @(posedge clk);
    #1;

    slow = 1'b1;
    step(1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    slow = 1'b0;
    step(3);
    lit_a("pause_spurious", lit(0, 1, 0, 0, 0, 0, 0));
    start = 1'b1;
    step(1);
    start = 1'b0;
    ticks(2);
    step(1);
    lit_a("resume", lit(0, 1, 0, 0, 2, 1, 0));

    ticks(35398);
    step(1);
    lit_a("limit_60", lit(6, 0, 0, 0, 0, 0, 1));
    ticks(5);
    start = 1'b1;
    step(2);
    stop = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    lit_a("done_hold", lit(6, 0, 0, 0, 0, 0, 1));
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    lit_a("clear_done", lit(0, 0, 0, 0, 0, 0, 0));

    start = 1'b1;
    step(1);
    start = 1'b0;
    ticks(3);
    step(1);
    lit_a("count_3", lit(0, 0, 0, 0, 3, 1, 0));
    slow = 1'b1;
    step(1);
    slow = 1'b0;
    step(1);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    lit_a("tick_stop", lit(0, 0, 0, 0, 3, 0, 0));

    start = 1'b1;
    step(1);
    start = 1'b0;
    slow = 1'b1;
    step(1);
    slow = 1'b0;
    step(1);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    lit_a("tick_clear", lit(0, 0, 0, 0, 0, 0, 0));

    start = 1'b1;
    stop  = 1'b1;
    step(1);
    start = 1'b0;
    stop  = 1'b0;
    lit_a("start_stop_idle", lit(0, 0, 0, 0, 0, 0, 0));

    start = 1'b1;
    step(1);
    start = 1'b0;
    ticks(4);
    step(1);
    lit_a("count_4", lit(0, 0, 0, 0, 4, 1, 0));
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    lit_a("reset_mid", lit(0, 0, 0, 0, 0, 0, 0));

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
